// File: rtl/double_stream_pkg.sv
// -----------------------------------------------------------------------------
// double_stream_pkg
// Shared definitions for the double-precision result stream path: word width,
// default FIFO depth, a constant ceil(log2) helper for deriving pointer widths,
// and a couple of IEEE-754 double constants used as recognisable test values.
// -----------------------------------------------------------------------------
package double_stream_pkg;

  localparam int DOUBLE_W           = 64;
  localparam int FIFO_DEPTH_DEFAULT = 8;

  localparam logic [63:0] DBL_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] DBL_QNAN = 64'h7FF8000000000000;

  typedef logic [DOUBLE_W-1:0] double_t;

  // Ceiling log2 for elaboration-time widths; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : double_stream_pkg

// File: rtl/double_fifo_ram.sv
// -----------------------------------------------------------------------------
// double_fifo_ram
// DEPTH x WIDTH storage for double_stream_fifo. One synchronous write port and
// one asynchronous (combinational) read port so the FIFO head is show-ahead.
// Contents are deliberately not reset.
//
// Ports:
//   i_clk      clock, writes on the rising edge
//   i_we       write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address (asynchronous)
//   o_rd_data  read data, mem[i_rd_addr]
// -----------------------------------------------------------------------------
module double_fifo_ram #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : double_fifo_ram

// File: rtl/double_stream_fifo.sv
// -----------------------------------------------------------------------------
// double_stream_fifo
// Elastic buffer between the double_adder result port and the file_writer
// input. Words pass through unmodified and in order using the data/_stb/_ack
// handshake on both sides. A transfer happens on a rising edge where stb and
// ack are both high.
//
// Optional build macro: DOUBLE_FIFO_HWM_EN
//   defined   -> high_water tracks peak occupancy since reset
//   undefined -> high_water is tied to 0, no register is built
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   input_a       write data from producer
//   input_a_stb   producer has valid data
//   input_a_ack   FIFO accepts the word (not full, not in reset)
//   output_z      head-of-queue data (show-ahead)
//   output_z_stb  head-of-queue valid (not empty)
//   output_z_ack  consumer takes the head
//   count         current occupancy, 0..DEPTH
//   high_water    peak occupancy since reset (see macro above)
// -----------------------------------------------------------------------------
module double_stream_fifo
  import double_stream_pkg::*;
#(
  parameter  int WIDTH  = DOUBLE_W,
  parameter  int DEPTH  = FIFO_DEPTH_DEFAULT,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  output logic [WIDTH-1:0]  output_z,
  output logic              output_z_stb,
  input  logic              output_z_ack,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   high_water
);

  localparam logic [ADDR_W:0]   C_EMPTY   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   C_FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_0   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_next;
  logic              w_in_ack;
  logic              w_out_stb;
  logic              w_push;
  logic              w_pop;
  logic [WIDTH-1:0]  w_rd_data;

  // Acceptance depends only on registered occupancy (and reset), never on the
  // consumer's ack, so a full FIFO refuses even if it pops this same cycle.
  assign w_in_ack  = (r_count != C_FULL) & ~rst;
  assign w_out_stb = (r_count != C_EMPTY);
  assign w_push    = input_a_stb & w_in_ack;
  assign w_pop     = w_out_stb & output_z_ack;

  // Occupancy next-state: +1 push only, -1 pop only, hold otherwise.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a
  // power of two, and count disambiguates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= C_PTR_0;
      r_rd_ptr <= C_PTR_0;
      r_count  <= C_EMPTY;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= w_count_next;
    end
  end

  double_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (clk),
    .i_we      (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (input_a),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

`ifdef DOUBLE_FIFO_HWM_EN
  logic [ADDR_W:0] r_high_water;

  // Peak occupancy: follows the next count upward, only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_water <= C_EMPTY;
    end else if (w_count_next > r_high_water) begin
      r_high_water <= w_count_next;
    end
  end

  assign high_water = r_high_water;
`else
  assign high_water = C_EMPTY;
`endif

  assign input_a_ack  = w_in_ack;
  assign output_z_stb = w_out_stb;
  assign output_z     = w_rd_data;
  assign count        = r_count;

endmodule : double_stream_fifo

// File: tb/tb_double_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_double_stream_fifo
// Directed bench for double_stream_fifo with a scoreboard queue: each accepted
// word is pushed when the handshake is seen, each popped word is compared with
// the queue head. Handshakes are observed on the falling edge, inputs are
// driven 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_double_stream_fifo;
  import double_stream_pkg::*;

  localparam int W  = DOUBLE_W;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic [W-1:0]  input_a;
  logic          input_a_stb;
  logic          input_a_ack;
  logic [W-1:0]  output_z;
  logic          output_z_stb;
  logic          output_z_ack;
  logic [AW:0]   count;
  logic [AW:0]   high_water;

  int            n_tests;
  int            n_fail;
  int            n_pop;
  logic          last_push;
  logic          last_in_ack;
  logic [W-1:0]  sb[$];
  logic [W-1:0]  exp_w;
  logic [63:0]   exp_hw;

  double_stream_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .count        (count),
    .high_water   (high_water)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes at the falling edge, return just after rise.
  task automatic step();
    @(negedge clk);
    last_in_ack = input_a_ack;
    last_push   = input_a_stb && input_a_ack;
    if (last_push) sb.push_back(input_a);
    if (output_z_stb && output_z_ack) begin
      n_pop++;
      exp_w = (sb.size() != 0) ? sb.pop_front() : ~output_z;
      chk("pop_data", output_z, exp_w);
    end
    @(posedge clk);
    #1;
  endtask

  // Pop everything out (bounded), then confirm the FIFO and scoreboard agree.
  task automatic drain(input string tag);
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    for (int k = 0; k < 40 && (count != 0); k++) step();
    output_z_ack = 1'b0;
    chk({tag, "_count0"}, 64'(count), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_pop = 0;
    rst = 1'b1; input_a = 64'd0; input_a_stb = 1'b0; output_z_ack = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 64'(input_a_ack), 64'd0);
    chk("rst_stb", 64'(output_z_stb), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_ack", 64'(input_a_ack), 64'd1);
    chk("idle_stb", 64'(output_z_stb), 64'd0);
    chk("idle_hw", 64'(high_water), 64'd0);
    step();
    chk("idle_count", 64'(count), 64'd0);

    // Single word, no same-cycle bypass
    input_a = DBL_ONE; input_a_stb = 1'b1; output_z_ack = 1'b1;
    step();
    input_a_stb = 1'b0;
    chk("single_stb", 64'(output_z_stb), 64'd1);
    chk("single_data", output_z, DBL_ONE);
    chk("single_count1", 64'(count), 64'd1);
    chk("single_nopop_yet", 64'(n_pop), 64'd0);
    step();
    chk("single_popped", 64'(n_pop), 64'd1);
    chk("single_count0", 64'(count), 64'd0);
    chk("single_stb0", 64'(output_z_stb), 64'd0);
    output_z_ack = 1'b0;

    // Fill to full, 9th word held, then drain in order
    n_pop = 0;
    for (int i = 1; i <= 8; i++) begin
      input_a = 64'(i); input_a_stb = 1'b1;
      step();
    end
    input_a = 64'd9;
    step(); step();
    chk("full_count", 64'(count), 64'd8);
    chk("full_ack", 64'(input_a_ack), 64'd0);
    chk("full_held", 64'(sb.size()), 64'd8);
    output_z_ack = 1'b1;
    step();
    chk("full_pop_no_push", 64'(last_in_ack), 64'd0);
    chk("full_after_pop", 64'(count), 64'd7);
    for (int k = 0; k < 30 && (input_a_stb || count != 0); k++) begin
      step();
      if (last_push) input_a_stb = 1'b0;
    end
    chk("fill_pops", 64'(n_pop), 64'd9);
    chk("fill_stb_dropped", 64'(input_a_stb), 64'd0);
    drain("fill");

    // Simultaneous push/pop at count 3 across pointer wrap
    n_pop = 0;
    for (int i = 0; i < 3; i++) begin
      input_a = 64'hA0 + 64'(i); input_a_stb = 1'b1;
      step();
    end
    chk("pp_count3", 64'(count), 64'd3);
    input_a = DBL_QNAN; output_z_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("pp_count_hold", 64'(count), 64'd3);
    end
    drain("pp");
    chk("pp_pops", 64'(n_pop), 64'd23);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      input_a = 64'h50 + 64'(i); input_a_stb = 1'b1;
      step();
    end
    input_a_stb = 1'b0;
    chk("mid_count5", 64'(count), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_stb", 64'(output_z_stb), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ack", 64'(input_a_ack), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_post_count", 64'(count), 64'd0);
    n_pop = 0;
    input_a = 64'hC000000000000000; input_a_stb = 1'b1; output_z_ack = 1'b1;
    step();
    input_a_stb = 1'b0;
    chk("mid_first_out", output_z, 64'hC000000000000000);
    step();
    chk("mid_one_pop", 64'(n_pop), 64'd1);
    output_z_ack = 1'b0;
    drain("mid");

    // High-water: push 6, pop 4, push 1
    for (int i = 0; i < 6; i++) begin
      input_a = 64'h60 + 64'(i); input_a_stb = 1'b1;
      step();
    end
    input_a_stb = 1'b0; output_z_ack = 1'b1;
    repeat (4) step();
    output_z_ack = 1'b0;
    input_a = 64'h70; input_a_stb = 1'b1;
    step();
    input_a_stb = 1'b0;
`ifdef DOUBLE_FIFO_HWM_EN
    exp_hw = 64'd6;
`else
    exp_hw = 64'd0;
`endif
    chk("hwm_count", 64'(count), 64'd3);
    chk("hwm_value", 64'(high_water), exp_hw);
    drain("hwm");
    chk("hwm_after_drain", 64'(high_water), exp_hw);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_double_stream_fifo

// File: doc/double_stream_fifo.md
Name: double_stream_fifo

Overview:
- Elastic buffer between the double_adder result port (output_z/_stb/_ack) and the file_writer input port.
- Absorbs back-pressure from the consumer so the adder can keep retiring results.
- Uses the codebase's data/_stb/_ack handshake on both sides and passes 64-bit IEEE-754 words through unmodified and in order.

Parameters:
- WIDTH, 64: data word width in bits.
- DEPTH, 8: number of storage entries; must be a power of 2 and at least 2.
- ADDR_W, log2(DEPTH): pointer width; derived, never overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_a  input  WIDTH  write data from the upstream producer.
- input_a_stb  input  1  producer has valid data.
- input_a_ack  output  1  FIFO accepts the word this cycle.
- output_z  output  WIDTH  head-of-queue data.
- output_z_stb  output  1  head-of-queue is valid.
- output_z_ack  input  1  consumer takes the head this cycle.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- high_water  output  ADDR_W+1  peak occupancy since reset (see Optional Feature).

Behaviour:
- Handshake transfer: a transfer occurs on a rising edge where stb and ack are both 1.
  - Producers hold stb and data stable until acked.
  - The FIFO never drops or duplicates a word.
- Reset (rst=1, asynchronous):
  - rd_ptr, wr_ptr and count go to 0; high_water goes to 0.
  - input_a_ack=0 and output_z_stb=0 while rst is asserted.
  - output_z is don't-care; storage contents are not cleared.
  - Reset mid-stream discards all held words. First acceptance is possible on the first edge after rst deasserts.
- input_a_ack = (count != DEPTH) and not rst. It is a function of registered state only; there is no combinational path from output_z_ack.
- output_z_stb = (count != 0). output_z = mem[rd_ptr], show-ahead: valid whenever output_z_stb=1.
- Push on input_a_stb & input_a_ack: mem[wr_ptr] <= input_a; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop on output_z_stb & output_z_ack: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Latency: a word pushed into an empty FIFO at edge N raises output_z_stb after edge N. It is first poppable at edge N+1. There is no same-cycle bypass.
- Full (count=DEPTH): input_a_ack=0 even if a pop happens in the same cycle. Acceptance resumes the cycle after count drops.
- Empty (count=0): output_z_stb=0; output_z_ack is ignored.
- Throughput: 1 word/cycle sustained when 0<count<DEPTH and both sides are active.
- Pointer wrap: indices run DEPTH-1 -> 0. count disambiguates full from empty; no extra wrap bit is required.

Optional Feature:
- Macro: DOUBLE_FIFO_HWM_EN.
- Defined: high_water is a register.
  - Reset value 0.
  - Each edge, high_water <= max(high_water, next count).
  - It never decreases except on rst.
- Undefined: high_water is tied to 0 and no register is built.
- The port list is identical in both builds.

Decomposition:
- Shared package double_stream_pkg:
  - DOUBLE_W=64 and FIFO_DEPTH_DEFAULT=8.
  - A clog2 constant function.
  - IEEE-754 constants for test values: DBL_ONE=64'h3FF0000000000000, DBL_QNAN=64'h7FF8000000000000.
- Sub-module double_fifo_ram: DEPTH x WIDTH storage.
  - One synchronous write port.
  - One asynchronous read port addressed by rd_ptr.
- Pointer, count and handshake logic stay in double_stream_fifo.

Test Plan:
- Reset then idle: rst pulse, producer idle.
  - -> count=0, output_z_stb=0, input_a_ack=1 after rst deasserts.
  - -> high_water=0.
- Single word: push 64'h3FF0000000000000 at edge N with output_z_ack=1.
  - -> output_z_stb=1 after edge N with output_z=3FF0000000000000.
  - -> popped at edge N+1; count returns to 0.
- Fill to full: output_z_ack=0, push words 1..8 (64'h1..64'h8).
  - -> count=8, input_a_ack=0, 9th word held by the producer.
  - -> then ack 8 pops: outputs 1..8 in order, then the 9th word is accepted.
- Simultaneous push/pop at count=3 for 20 cycles, pushing 64'h7FF8000000000000 each cycle.
  - -> count stays 3; 20 words out match 20 in, in order, across pointer wrap.
- Reset mid-stream: count=5, assert rst asynchronously between edges.
  - -> output_z_stb and count drop immediately.
  - -> after release, the next pushed word 64'hC000000000000000 is the first output.
- HWM (DOUBLE_FIFO_HWM_EN defined): push 6, pop 4, push 1.
  - -> high_water=6, count=3.
  - -> with the macro undefined, high_water=0 throughout.
